// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
//   Shared constants and types for the instruction fetch front end.
//   - XLEN        : architectural word / address width
//   - NOP_INSTR   : canonical NOP (addi x0,x0,0) shown to decode on empty slots
//   - PC_INC      : sequential fetch stride in bytes
//   - fetch_state_e : fetch sequencer states
//   - fetch_entry_t : one buffered instruction together with its PC
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INC    = 32'd4;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,  // one idle cycle after reset, no requests
    S_RUN   = 2'd1,  // normal sequential fetching
    S_DRAIN = 2'd2   // discarding responses of requests made before a redirect
  } fetch_state_e;

  // Packed as {pc, inst} so the buffer stores one 64-bit word per entry.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with registered output (no push-to-pop bypass).
//   DEPTH must be a power of two >= 2 so the pointers wrap naturally.
//   Ports:
//     clk_in        : clock, all updates on the rising edge
//     rst_n_in      : synchronous active-low reset (empties the FIFO)
//     clear_in      : synchronous flush, drops contents and any same-cycle push
//     push_in       : write push_data_in (ignored when full)
//     push_data_in  : data to write
//     pop_in        : remove the head entry (ignored when empty)
//     head_data_out : current head entry (meaningless when empty_out=1)
//     empty_out     : no entries stored
//     count_out     : number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             clear_in,
  input  logic             push_in,
  input  logic [WIDTH-1:0] push_data_in,
  input  logic             pop_in,
  output logic [WIDTH-1:0] head_data_out,
  output logic             empty_out,
  output logic [CW-1:0]    count_out
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_full    = (r_count == CW'(DEPTH));
  assign empty_out = (r_count == '0);
  assign count_out = r_count;

  // A clear discards everything, including whatever arrives in the same cycle.
  assign w_push = push_in & ~w_full & ~clear_in;
  assign w_pop  = pop_in & ~empty_out & ~clear_in;

  assign head_data_out = r_mem[r_rd_ptr];

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in || clear_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;  // idle, or push and pop cancel out
      endcase
    end
  end

  // NOTE: the storage array has no reset; validity is tracked solely by the
  // pointers and count, so stale contents are never observed.
  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data_in;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch front end: owns the fetch PC, issues in-order word requests to
//   instruction memory (req/gnt + in-order rvalid), buffers returned words
//   and presents one instruction per cycle to decode.
//   Ports:
//     clk_in, rst_n_in        : clock, synchronous active-low reset
//     stall_in                : decode cannot accept; hold inst_out/pc_out
//     branch_taken_in         : one-cycle redirect request from execute
//     branch_pc_in            : redirect target, low two bits ignored
//     imem_req_out            : fetch request valid
//     imem_addr_out           : word address of the request
//     imem_gnt_in             : request accepted this cycle
//     imem_rvalid_in          : read data valid (in request order)
//     imem_rdata_in           : read data
//     inst_out / pc_out       : instruction and its PC (NOP / 0 when empty)
//     inst_valid_out          : inst_out is a real fetched instruction
//     flush_out               : inverse of inst_valid_out
// ---------------------------------------------------------------------------
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            stall_in,
  input  logic            branch_taken_in,
  input  logic [XLEN-1:0] branch_pc_in,
  output logic            imem_req_out,
  output logic [XLEN-1:0] imem_addr_out,
  input  logic            imem_gnt_in,
  input  logic            imem_rvalid_in,
  input  logic [XLEN-1:0] imem_rdata_in,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] pc_out,
  output logic            inst_valid_out,
  output logic            flush_out
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;  // counter width, holds 0..FIFO_DEPTH
  localparam int OW = CW + 1;                  // occupancy sum width

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;

  logic [XLEN-1:0] r_fetch_pc;     // address of the next request
  logic [XLEN-1:0] r_resp_pc;      // PC belonging to the next accepted response
  logic [CW-1:0]   r_outstanding;  // live requests granted but not yet returned
  logic [CW-1:0]   r_kill_cnt;     // pre-redirect responses still to be discarded

  logic [CW-1:0]   w_kill_nxt;
  logic [CW-1:0]   w_fifo_count;
  logic [OW-1:0]   w_occupancy;
  logic            w_redirect;
  logic            w_req;
  logic            w_fire;
  logic            w_accept;
  logic            w_retire;
  logic            w_fifo_empty;
  logic            w_pop;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;

  // Redirects are ignored in S_BOOT; everywhere else they take priority.
  assign w_redirect = branch_taken_in & (r_state != S_BOOT);

  assign w_fire = w_req & imem_gnt_in;

  // A returning word is kept unless it belongs to a killed request or the
  // redirect cycle itself.
  assign w_accept = imem_rvalid_in & (r_state != S_DRAIN) & ~w_redirect;
  assign w_retire = imem_rvalid_in & (r_state == S_RUN);

  // Requests that were granted before (or together with) the redirect are
  // all in flight from the new path's point of view. In S_RUN r_kill_cnt is
  // zero; in S_DRAIN r_outstanding is zero and no request fires, so one sum
  // covers both cases.
  assign w_kill_nxt = r_kill_cnt + r_outstanding + CW'(w_fire) - CW'(imem_rvalid_in);

  // Requests plus buffered words never exceed the buffer, so every response
  // is guaranteed a slot.
  assign w_occupancy = {1'b0, r_outstanding} + {1'b0, w_fifo_count};

  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    unique case (r_state)
      S_BOOT: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_req = (w_occupancy < OW'(FIFO_DEPTH));
      end
      S_DRAIN: begin
        if (imem_rvalid_in && (r_kill_cnt == CW'(1))) w_state_nxt = S_RUN;
      end
      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase
    if (w_redirect) w_state_nxt = (w_kill_nxt != '0) ? S_DRAIN : S_RUN;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state       <= S_BOOT;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_kill_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_redirect) begin
        r_fetch_pc    <= word_align(branch_pc_in);
        r_resp_pc     <= word_align(branch_pc_in);
        r_outstanding <= '0;
        r_kill_cnt    <= w_kill_nxt;
      end else begin
        if (w_fire)   r_fetch_pc <= r_fetch_pc + PC_INC;
        if (w_accept) r_resp_pc  <= r_resp_pc + PC_INC;
        unique case ({w_fire, w_retire})
          2'b10:   r_outstanding <= r_outstanding + CW'(1);
          2'b01:   r_outstanding <= r_outstanding - CW'(1);
          default: r_outstanding <= r_outstanding;
        endcase
        if ((r_state == S_DRAIN) && imem_rvalid_in) r_kill_cnt <= r_kill_cnt - CW'(1);
      end
    end
  end

  assign w_push_entry = '{pc: r_resp_pc, inst: imem_rdata_in};

  sync_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_inst_buf (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .clear_in      (w_redirect),
    .push_in       (w_accept),
    .push_data_in  (w_push_entry),
    .pop_in        (w_pop),
    .head_data_out (w_head),
    .empty_out     (w_fifo_empty),
    .count_out     (w_fifo_count)
  );

  // The head is hidden combinationally in a redirect cycle so decode never
  // sees a wrong-path instruction.
  assign inst_valid_out = ~w_fifo_empty & ~branch_taken_in;
  assign flush_out      = ~inst_valid_out;
  assign w_pop          = inst_valid_out & ~stall_in;

  assign inst_out      = inst_valid_out ? w_head.inst : NOP_INSTR;
  assign pc_out        = inst_valid_out ? w_head.pc   : '0;
  assign imem_req_out  = w_req;
  assign imem_addr_out = r_fetch_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Randomized bench with an in-order memory model and a scoreboard. The
//   reference model tracks the fetch PC, the list of in-flight requests
//   (tagged with a redirect epoch) and the queue of instructions decode
//   should receive; a separate monitor pops that queue as decode consumes.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        stall_in = 1'b0;
  logic        branch_taken_in = 1'b0;
  logic [31:0] branch_pc_in = '0;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_gnt_in = 1'b0;
  logic        imem_rvalid_in = 1'b0;
  logic [31:0] imem_rdata_in = '0;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        inst_valid_out;
  logic        flush_out;

  instr_fetch_unit #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .stall_in        (stall_in),
    .branch_taken_in (branch_taken_in),
    .branch_pc_in    (branch_pc_in),
    .imem_req_out    (imem_req_out),
    .imem_addr_out   (imem_addr_out),
    .imem_gnt_in     (imem_gnt_in),
    .imem_rvalid_in  (imem_rvalid_in),
    .imem_rdata_in   (imem_rdata_in),
    .inst_out        (inst_out),
    .pc_out          (pc_out),
    .inst_valid_out  (inst_valid_out),
    .flush_out       (flush_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          tag;
    int          ready;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  pend_t pend_q[$];  // memory model: granted requests awaiting response
  exp_t  exp_q[$];   // scoreboard: instructions decode should see, in order

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus controls
  logic        d_rst_n = 1'b0;
  logic        d_stall = 1'b0;
  logic        d_branch = 1'b0;
  logic [31:0] d_bpc = '0;
  int          gnt_mode = 0;   // 0 always grant, 1 random, 2 withhold
  int          lat_min = 1;
  int          lat_max = 1;
  int          data_mode = 0;  // 0 data=address, 1 hashed

  // Reference model state
  logic [31:0] m_pc = RESET_PC;
  bit          m_boot = 1'b1;
  int          epoch = 0;
  int          cyc = 0;
  bit          chk_en = 1'b0;
  int          rel_cnt = 0;
  bit          meas_lat = 1'b0;
  int          first_lat = -1;

  // Values sampled in the most recent cycle
  logic        s_req, s_valid, s_flush;
  logic [31:0] s_addr, s_inst, s_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (data_mode == 0) return a;
    return (a * 32'h9E37_79B9) ^ 32'hC001_D00D;
  endfunction

  // Fetch may request only when it is running on the current path and the
  // live requests plus buffered words leave room in the buffer.
  function automatic bit model_req();
    int live;
    bit drain;
    live  = 0;
    drain = 1'b0;
    foreach (pend_q[i]) begin
      if (pend_q[i].tag == epoch) live++;
      else drain = 1'b1;
    end
    if (m_boot || drain) return 1'b0;
    return (live + exp_q.size()) < DEPTH;
  endfunction

  // One clock cycle: drive at negedge, check the fetch side 3 units later,
  // advance the model at the rising edge.
  task automatic cycle();
    bit          g;
    logic        granted;
    logic        got;
    logic [31:0] a;
    pend_t       p;
    exp_t        e;
    bit          redirect;

    @(negedge clk_in);
    rst_n_in        = d_rst_n;
    stall_in        = d_stall;
    branch_taken_in = d_branch;
    branch_pc_in    = d_bpc;
    case (gnt_mode)
      0:       g = 1'b1;
      1:       g = ($urandom_range(0, 99) < 70);
      default: g = 1'b0;
    endcase
    imem_gnt_in = d_rst_n & g;
    if (d_rst_n && pend_q.size() > 0 && pend_q[0].ready <= cyc) begin
      imem_rvalid_in = 1'b1;
      imem_rdata_in  = pend_q[0].data;
    end else begin
      imem_rvalid_in = 1'b0;
      imem_rdata_in  = $urandom;
    end

    #3;
    s_req   = imem_req_out;
    s_addr  = imem_addr_out;
    s_valid = inst_valid_out;
    s_flush = flush_out;
    s_inst  = inst_out;
    s_pc    = pc_out;
    if (chk_en) begin
      check("imem_req", {31'd0, imem_req_out}, {31'd0, model_req()});
      check("imem_addr", imem_addr_out, m_pc);
      if (meas_lat && inst_valid_out === 1'b1) begin
        first_lat = rel_cnt;
        meas_lat  = 1'b0;
      end
    end
    granted = imem_req_out & imem_gnt_in;
    got     = imem_rvalid_in;
    a       = imem_addr_out;

    @(posedge clk_in);
    if (!d_rst_n) begin
      pend_q.delete();
      exp_q.delete();
      m_pc    = RESET_PC;
      m_boot  = 1'b1;
      chk_en  = 1'b1;
      rel_cnt = 0;
    end else begin
      rel_cnt++;
      redirect = d_branch && !m_boot;
      if (granted === 1'b1) begin
        p.addr  = a;
        p.data  = mem_data(a);
        p.tag   = epoch;
        p.ready = cyc + int'($urandom_range(lat_min, lat_max));
        pend_q.push_back(p);
      end
      if (got) begin
        p = pend_q.pop_front();
        if (p.tag == epoch && !redirect) begin
          e.pc   = p.addr;
          e.inst = p.data;
          exp_q.push_back(e);
        end
      end
      if (redirect) begin
        epoch++;
        exp_q.delete();
        m_pc = d_bpc & ~32'h3;
      end else if (granted === 1'b1) begin
        m_pc = m_pc + 32'd4;
      end
      m_boot = 1'b0;
    end
    cyc++;
  endtask

  // Decode-side monitor: compares what decode sees against the scoreboard
  // head and consumes it when decode is not stalled.
  logic m_ev;
  initial begin
    forever begin
      @(negedge clk_in);
      #4;
      if (chk_en) begin
        m_ev = (exp_q.size() > 0) && !branch_taken_in;
        check("inst_valid", {31'd0, inst_valid_out}, {31'd0, m_ev});
        check("flush", {31'd0, flush_out}, {31'd0, !m_ev});
        if (m_ev) begin
          check("inst_out", inst_out, exp_q[0].inst);
          check("pc_out", pc_out, exp_q[0].pc);
          if (!stall_in) void'(exp_q.pop_front());
        end else begin
          check("inst_out_nop", inst_out, NOP_INSTR);
          check("pc_out_zero", pc_out, 32'h0);
        end
      end
    end
  end

  initial begin
    bit found;
    bit hit;

    // Reset, then full-speed memory returning the address as data.
    repeat (3) cycle();
    d_rst_n  = 1'b1;
    meas_lat = 1'b1;
    repeat (14) cycle();
    check("first_valid_latency", 32'(first_lat), 32'd3);

    // Decode stall: buffer fills, requests stop, nothing lost on release.
    d_stall = 1'b1;
    repeat (5) cycle();
    check("stall_req_dropped", {31'd0, s_req}, 32'd0);
    d_stall = 1'b0;
    repeat (10) cycle();

    // Grant withheld: address must hold.
    gnt_mode = 2;
    repeat (3) cycle();
    gnt_mode = 0;
    repeat (6) cycle();

    // Redirect with two requests in flight.
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 20 && pend_q.size() != 2; i++) cycle();
    check("inflight_before_branch", 32'(pend_q.size()), 32'd2);
    d_branch = 1'b1;
    d_bpc    = 32'h0000_0103;
    cycle();
    d_branch = 1'b0;
    check("flush_on_branch", {31'd0, s_flush}, 32'd1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (s_valid === 1'b1) found = 1'b1;
    end
    check("branch_first_valid_seen", {31'd0, found}, 32'd1);
    if (found) check("branch_first_pc", s_pc, 32'h0000_0100);

    // Redirect coinciding with a grant and a response.
    lat_min = 1;
    lat_max = 1;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (model_req() && pend_q.size() > 0 && pend_q[0].ready <= cyc) begin
        d_branch = 1'b1;
        d_bpc    = 32'h0000_2206;
        hit      = 1'b1;
      end
      cycle();
      d_branch = 1'b0;
    end
    check("coincident_redirect_hit", {31'd0, hit}, 32'd1);
    repeat (8) cycle();

    // Reset with the buffer full.
    d_stall = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != DEPTH; i++) cycle();
    check("fifo_full_before_reset", 32'(exp_q.size()), 32'(DEPTH));
    d_rst_n = 1'b0;
    cycle();
    d_rst_n = 1'b1;
    d_stall = 1'b0;
    cycle();
    check("reset_flush", {31'd0, s_flush}, 32'd1);
    check("reset_inst_nop", s_inst, NOP_INSTR);
    check("reset_req_low", {31'd0, s_req}, 32'd0);
    check("reset_addr", s_addr, RESET_PC);
    repeat (5) cycle();

    // Randomized traffic: grants, latencies, stalls, redirects, resets.
    gnt_mode  = 1;
    lat_min   = 1;
    lat_max   = 4;
    data_mode = 1;
    for (int i = 0; i < 1500; i++) begin
      d_stall = ($urandom_range(0, 99) < 30);
      d_rst_n = ($urandom_range(0, 199) != 0);
      if (d_rst_n && !m_boot && $urandom_range(0, 99) < 4) begin
        d_branch = 1'b1;
        d_bpc    = $urandom;
      end else begin
        d_branch = 1'b0;
      end
      cycle();
    end
    d_branch = 1'b0;
    d_stall  = 1'b0;
    d_rst_n  = 1'b1;
    repeat (10) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
